// File: rtl/ct_ifu_lbuf_read_ctrl.sv
// Loop-buffer read controller: walks halfword entries, assembles 16/32-bit instructions into a
// one-deep output stage. Define LBUF_LOOP_CNT_EN to enable the saturating loop-iteration counter.
module ct_ifu_lbuf_read_ctrl #(
    parameter int ENTRY_NUM = 16,
    parameter int PTR_W     = 4
) (
    input  logic                    lbuf_vld_update_clk,
    input  logic                    cpurst_b,
    input  logic                    lbuf_flush,
    input  logic                    fill_state_enter,
    input  logic                    lbuf_active_start,
    input  logic [PTR_W-1:0]        lbuf_loop_start_ptr,
    input  logic [ENTRY_NUM-1:0]    entry_vld,
    input  logic [16*ENTRY_NUM-1:0] entry_inst_data,
    input  logic [ENTRY_NUM-1:0]    entry_32_start,
    input  logic [ENTRY_NUM-1:0]    entry_back_br,
    input  logic [ENTRY_NUM-1:0]    entry_fence,
    input  logic                    ib_lbuf_ready,
    output logic                    lbuf_inst_vld,
    output logic [31:0]             lbuf_inst_data,
    output logic                    lbuf_inst_32,
    output logic                    lbuf_inst_back_br,
    output logic [PTR_W-1:0]        lbuf_rd_ptr,
    output logic                    lbuf_rd_exit,
    output logic [7:0]              lbuf_loop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXIT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             vld_q, vld_d;
    logic [31:0]      data_q, data_d;
    logic             is32_q, is32_d;
    logic             bbr_q, bbr_d;
    logic             exit_q, exit_d;

    logic             kill;
    logic             free;
    logic             fetch;
    logic [PTR_W-1:0] ptr_p1;
    logic [PTR_W-1:0] ptr_p2;
    logic [15:0]      lo_half;
    logic [15:0]      hi_half;
    logic             cur_32;
    logic             cur_bbr;
    logic             cur_fence;

    assign kill      = lbuf_flush | fill_state_enter;
    assign free      = !vld_q || ib_lbuf_ready;
    assign ptr_p1    = rd_ptr_q + PTR_W'(1);
    assign ptr_p2    = rd_ptr_q + PTR_W'(2);
    assign lo_half   = entry_inst_data[{rd_ptr_q, 4'b0000} +: 16];
    assign hi_half   = entry_inst_data[{ptr_p1, 4'b0000} +: 16];
    // Instruction attributes come only from the start halfword.
    assign cur_32    = entry_32_start[rd_ptr_q];
    assign cur_bbr   = entry_back_br[rd_ptr_q];
    assign cur_fence = entry_fence[rd_ptr_q];
    assign fetch     = (state_q == ST_READ) && free && entry_vld[rd_ptr_q]
                       && (!cur_32 || entry_vld[ptr_p1]);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        vld_d    = vld_q && !ib_lbuf_ready;
        data_d   = data_q;
        is32_d   = is32_q;
        bbr_d    = bbr_q;
        exit_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (lbuf_active_start) begin
                    state_d  = ST_READ;
                    rd_ptr_d = lbuf_loop_start_ptr;
                end
            end
            ST_READ: begin
                if (fetch) begin
                    vld_d    = 1'b1;
                    data_d   = cur_32 ? {hi_half, lo_half} : {16'h0000, lo_half};
                    is32_d   = cur_32;
                    bbr_d    = cur_bbr;
                    rd_ptr_d = cur_bbr ? lbuf_loop_start_ptr : (cur_32 ? ptr_p2 : ptr_p1);
                    if (cur_fence) state_d = ST_EXIT;
                end
            end
            ST_EXIT: begin
                if (free) begin
                    exit_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (kill) begin
            state_d  = ST_IDLE;
            rd_ptr_d = '0;
            vld_d    = 1'b0;
            exit_d   = 1'b0;
        end
    end

    always_ff @(posedge lbuf_vld_update_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q  <= ST_IDLE;
            rd_ptr_q <= '0;
            vld_q    <= 1'b0;
            data_q   <= '0;
            is32_q   <= 1'b0;
            bbr_q    <= 1'b0;
            exit_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all state updates see pre-edge values.
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            vld_q    <= vld_d;
            data_q   <= data_d;
            is32_q   <= is32_d;
            bbr_q    <= bbr_d;
            exit_q   <= exit_d;
        end
    end

`ifdef LBUF_LOOP_CNT_EN
    logic [7:0] loop_cnt_q, loop_cnt_d;

    always_comb begin
        loop_cnt_d = loop_cnt_q;
        if (kill || (state_q == ST_IDLE && lbuf_active_start)) begin
            loop_cnt_d = '0;
        end else if (fetch && cur_bbr && (loop_cnt_q != 8'hff)) begin
            loop_cnt_d = loop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge lbuf_vld_update_clk or negedge cpurst_b) begin
        if (!cpurst_b) loop_cnt_q <= '0;
        else           loop_cnt_q <= loop_cnt_d;
    end

    assign lbuf_loop_cnt = loop_cnt_q;
`else
    assign lbuf_loop_cnt = 8'd0;
`endif

    assign lbuf_inst_vld     = vld_q;
    assign lbuf_inst_data    = data_q;
    assign lbuf_inst_32      = is32_q;
    assign lbuf_inst_back_br = bbr_q;
    assign lbuf_rd_ptr       = rd_ptr_q;
    assign lbuf_rd_exit      = exit_q;

endmodule

// File: tb/tb_ct_ifu_lbuf_read_ctrl.sv
// Directed bench for ct_ifu_lbuf_read_ctrl; accepted instructions are compared against a
// scoreboard queue filled as each fetch is set up.
module tb_ct_ifu_lbuf_read_ctrl;

    localparam int ENTRY_NUM = 16;
    localparam int PTR_W     = 4;

    typedef struct {
        logic [31:0] data;
        logic        is32;
        logic        bbr;
    } exp_t;

    logic                    clk;
    logic                    rst_b;
    logic                    lbuf_flush;
    logic                    fill_state_enter;
    logic                    lbuf_active_start;
    logic [PTR_W-1:0]        lbuf_loop_start_ptr;
    logic [ENTRY_NUM-1:0]    entry_vld;
    logic [16*ENTRY_NUM-1:0] entry_inst_data;
    logic [ENTRY_NUM-1:0]    entry_32_start;
    logic [ENTRY_NUM-1:0]    entry_back_br;
    logic [ENTRY_NUM-1:0]    entry_fence;
    logic                    ib_lbuf_ready;
    logic                    lbuf_inst_vld;
    logic [31:0]             lbuf_inst_data;
    logic                    lbuf_inst_32;
    logic                    lbuf_inst_back_br;
    logic [PTR_W-1:0]        lbuf_rd_ptr;
    logic                    lbuf_rd_exit;
    logic [7:0]              lbuf_loop_cnt;

    logic [15:0] ent [ENTRY_NUM];
    exp_t        exp_q [$];
    int          checks;
    int          errors;
    logic [7:0]  cnt_exp;

    ct_ifu_lbuf_read_ctrl #(.ENTRY_NUM(ENTRY_NUM), .PTR_W(PTR_W)) dut (
        .lbuf_vld_update_clk (clk),
        .cpurst_b            (rst_b),
        .lbuf_flush          (lbuf_flush),
        .fill_state_enter    (fill_state_enter),
        .lbuf_active_start   (lbuf_active_start),
        .lbuf_loop_start_ptr (lbuf_loop_start_ptr),
        .entry_vld           (entry_vld),
        .entry_inst_data     (entry_inst_data),
        .entry_32_start      (entry_32_start),
        .entry_back_br       (entry_back_br),
        .entry_fence         (entry_fence),
        .ib_lbuf_ready       (ib_lbuf_ready),
        .lbuf_inst_vld       (lbuf_inst_vld),
        .lbuf_inst_data      (lbuf_inst_data),
        .lbuf_inst_32        (lbuf_inst_32),
        .lbuf_inst_back_br   (lbuf_inst_back_br),
        .lbuf_rd_ptr         (lbuf_rd_ptr),
        .lbuf_rd_exit        (lbuf_rd_exit),
        .lbuf_loop_cnt       (lbuf_loop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        entry_inst_data = '0;
        for (int i = 0; i < ENTRY_NUM; i++) entry_inst_data[16*i +: 16] = ent[i];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] data, input logic is32, input logic bbr);
        exp_t e;
        e.data = data;
        e.is32 = is32;
        e.bbr  = bbr;
        exp_q.push_back(e);
    endtask

    // Compares an instruction accepted at the coming edge, then advances one cycle.
    task automatic tick();
        exp_t e;
        if (lbuf_inst_vld && ib_lbuf_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", 64'(lbuf_inst_data), 64'(e.data));
                check("sb_inst_32", 64'(lbuf_inst_32), 64'(e.is32));
                check("sb_back_br", 64'(lbuf_inst_back_br), 64'(e.bbr));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int idx;
        checks = 0;
        errors = 0;
`ifdef LBUF_LOOP_CNT_EN
        cnt_exp = 8'd2;
`else
        cnt_exp = 8'd0;
`endif
        rst_b               = 1'b0;
        lbuf_flush          = 1'b0;
        fill_state_enter    = 1'b0;
        lbuf_active_start   = 1'b0;
        lbuf_loop_start_ptr = '0;
        entry_vld           = '0;
        entry_32_start      = '0;
        entry_back_br       = '0;
        entry_fence         = '0;
        ib_lbuf_ready       = 1'b0;
        for (int i = 0; i < ENTRY_NUM; i++) ent[i] = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld", 64'(lbuf_inst_vld), 64'd0);
        check("rst_data", 64'(lbuf_inst_data), 64'd0);
        check("rst_32", 64'(lbuf_inst_32), 64'd0);
        check("rst_bbr", 64'(lbuf_inst_back_br), 64'd0);
        check("rst_ptr", 64'(lbuf_rd_ptr), 64'd0);
        check("rst_exit", 64'(lbuf_rd_exit), 64'd0);
        check("rst_cnt", 64'(lbuf_loop_cnt), 64'd0);
        rst_b = 1'b1;
        tick();

        // 32-bit instruction from entries 3/4
        ent[3] = 16'h1234;
        ent[4] = 16'hABCD;
        entry_32_start[3] = 1'b1;
        entry_vld[3] = 1'b1;
        entry_vld[4] = 1'b1;
        ib_lbuf_ready = 1'b1;
        lbuf_loop_start_ptr = 4'd3;
        lbuf_active_start = 1'b1;
        tick();
        lbuf_active_start = 1'b0;
        check("start_ptr", 64'(lbuf_rd_ptr), 64'd3);
        check("start_vld", 64'(lbuf_inst_vld), 64'd0);
        push(32'hABCD1234, 1'b1, 1'b0);
        tick();
        check("i32_vld", 64'(lbuf_inst_vld), 64'd1);
        check("i32_data", 64'(lbuf_inst_data), 64'hABCD1234);
        check("i32_ptr", 64'(lbuf_rd_ptr), 64'd5);
        tick();
        check("underrun_vld", 64'(lbuf_inst_vld), 64'd0);
        check("underrun_ptr", 64'(lbuf_rd_ptr), 64'd5);

        // Loop body 3..6 of 16-bit instructions, back branch at 6
        entry_32_start = '0;
        entry_vld = 16'b0000_0000_0111_1000;
        entry_back_br[6] = 1'b1;
        for (int i = 3; i <= 6; i++) ent[i] = 16'h1000 + 16'(i);
        lbuf_flush = 1'b1;
        tick();
        lbuf_flush = 1'b0;
        check("flush1_ptr", 64'(lbuf_rd_ptr), 64'd0);
        check("flush1_vld", 64'(lbuf_inst_vld), 64'd0);
        lbuf_active_start = 1'b1;
        tick();
        lbuf_active_start = 1'b0;
        check("loop_start_ptr", 64'(lbuf_rd_ptr), 64'd3);
        check("loop_cnt_clr", 64'(lbuf_loop_cnt), 64'd0);
        for (int k = 0; k < 8; k++) begin
            idx = 3 + (k % 4);
            push({16'h0000, ent[idx]}, 1'b0, idx == 6);
            tick();
            check($sformatf("loop_ptr_%0d", k), 64'(lbuf_rd_ptr), (idx == 6) ? 64'd3 : 64'(idx + 1));
        end
        check("loop_cnt_2", 64'(lbuf_loop_cnt), 64'(cnt_exp));

        // Back-pressure: output and pointer hold
        ib_lbuf_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("hold_vld_%0d", k), 64'(lbuf_inst_vld), 64'd1);
            check($sformatf("hold_data_%0d", k), 64'(lbuf_inst_data), 64'h00001006);
            check($sformatf("hold_ptr_%0d", k), 64'(lbuf_rd_ptr), 64'd3);
        end

        // Fence at entry 3 ends replay
        entry_fence[3] = 1'b1;
        ib_lbuf_ready = 1'b1;
        push(32'h00001003, 1'b0, 1'b0);
        tick();
        check("fence_ptr", 64'(lbuf_rd_ptr), 64'd4);
        check("fence_vld", 64'(lbuf_inst_vld), 64'd1);
        check("fence_exit_early", 64'(lbuf_rd_exit), 64'd0);
        tick();
        check("exit_pulse", 64'(lbuf_rd_exit), 64'd1);
        check("exit_vld", 64'(lbuf_inst_vld), 64'd0);
        tick();
        check("exit_one_cycle", 64'(lbuf_rd_exit), 64'd0);
        check("idle_ptr_hold", 64'(lbuf_rd_ptr), 64'd4);
        check("idle_vld", 64'(lbuf_inst_vld), 64'd0);
        check("cnt_after_fence", 64'(lbuf_loop_cnt), 64'(cnt_exp));

        // Wrap: 32-bit instruction at 15 with upper half in entry 0
        entry_fence = '0;
        entry_back_br = '0;
        entry_vld = '0;
        entry_vld[15] = 1'b1;
        entry_32_start[15] = 1'b1;
        ent[15] = 16'h5555;
        ent[0] = 16'h6666;
        lbuf_loop_start_ptr = 4'd15;
        lbuf_active_start = 1'b1;
        tick();
        lbuf_active_start = 1'b0;
        check("wrap_start_ptr", 64'(lbuf_rd_ptr), 64'd15);
        check("wrap_cnt_clr", 64'(lbuf_loop_cnt), 64'd0);
        tick();
        check("wrap_wait_vld", 64'(lbuf_inst_vld), 64'd0);
        check("wrap_wait_ptr", 64'(lbuf_rd_ptr), 64'd15);
        entry_vld[0] = 1'b1;
        push(32'h66665555, 1'b1, 1'b0);
        tick();
        check("wrap_vld", 64'(lbuf_inst_vld), 64'd1);
        check("wrap_data", 64'(lbuf_inst_data), 64'h66665555);
        check("wrap_ptr", 64'(lbuf_rd_ptr), 64'd1);

        // Flush with simultaneous accept and pending fetch at entry 1
        entry_vld[1] = 1'b1;
        ent[1] = 16'h7777;
        lbuf_flush = 1'b1;
        tick();
        lbuf_flush = 1'b0;
        check("flush2_vld", 64'(lbuf_inst_vld), 64'd0);
        check("flush2_ptr", 64'(lbuf_rd_ptr), 64'd0);
        check("flush2_exit", 64'(lbuf_rd_exit), 64'd0);
        tick();
        check("flush2_idle_vld", 64'(lbuf_inst_vld), 64'd0);
        check("flush2_idle_ptr", 64'(lbuf_rd_ptr), 64'd0);
        check("flush2_idle_exit", 64'(lbuf_rd_exit), 64'd0);

        // fill_state_enter blocks the fetch of entry 0
        lbuf_loop_start_ptr = 4'd0;
        lbuf_active_start = 1'b1;
        tick();
        lbuf_active_start = 1'b0;
        check("fill_start_ptr", 64'(lbuf_rd_ptr), 64'd0);
        fill_state_enter = 1'b1;
        tick();
        fill_state_enter = 1'b0;
        check("fill_ptr", 64'(lbuf_rd_ptr), 64'd0);
        check("fill_vld", 64'(lbuf_inst_vld), 64'd0);
        tick();
        check("fill_idle_vld", 64'(lbuf_inst_vld), 64'd0);

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ct_ifu_lbuf_read_ctrl.md
Name: ct_ifu_lbuf_read_ctrl

Overview:
Read-side controller for the IFU loop buffer. It walks the per-halfword loop-buffer entries with a read pointer and assembles 16-bit or 32-bit instructions. Each instruction is presented through a one-deep registered output stage to the instruction buffer. On a back branch the pointer redirects to the loop start; a fence instruction terminates replay.

Parameters:
ENTRY_NUM, 16, number of halfword entries (power of 2)
PTR_W, 4, log2(ENTRY_NUM)

Ports:
lbuf_vld_update_clk  in  1  clock
cpurst_b  in  1  reset
lbuf_flush  in  1  flush; highest priority
fill_state_enter  in  1  buffer re-fill starting; same effect as flush
lbuf_active_start  in  1  begin replay (sampled in IDLE only)
lbuf_loop_start_ptr  in  PTR_W  entry index of loop body start
entry_vld  in  ENTRY_NUM  per-entry valid
entry_inst_data  in  16*ENTRY_NUM  entry i at [16i+15:16i]
entry_32_start  in  ENTRY_NUM  halfword starts a 32-bit inst
entry_back_br  in  ENTRY_NUM  halfword starts the loop back branch
entry_fence  in  ENTRY_NUM  halfword starts a fence-type inst
ib_lbuf_ready  in  1  consumer accepts output this cycle
lbuf_inst_vld  out  1  output instruction valid
lbuf_inst_data  out  32  instruction; 16-bit inst zero-extended
lbuf_inst_32  out  1  output is 32-bit
lbuf_inst_back_br  out  1  output is the back branch
lbuf_rd_ptr  out  PTR_W  current read pointer
lbuf_rd_exit  out  1  replay finished pulse
lbuf_loop_cnt  out  8  completed loop iterations

Behaviour:
- Interface (already decided): reset cpurst_b, asynchronous, active-low; clock lbuf_vld_update_clk.
- Reset values:
  - state=IDLE; rd_ptr=0.
  - All outputs 0.
- States:
  - IDLE:
    - lbuf_active_start → rd_ptr<=lbuf_loop_start_ptr, loop_cnt<=0, go READ.
  - READ: fetch rules below.
  - EXIT:
    - Wait until the output stage is empty (lbuf_inst_vld=0, or it is accepted this cycle).
    - Then assert lbuf_rd_exit for exactly 1 cycle and go IDLE.
- Priority:
  - lbuf_flush or fill_state_enter in any state → next cycle state=IDLE, lbuf_inst_vld=0, rd_ptr=0, loop_cnt=0, no exit pulse.
  - Override everything, including a simultaneous accept or active_start.
- Output stage:
  - free = !lbuf_inst_vld || ib_lbuf_ready.
  - Accept = lbuf_inst_vld && ib_lbuf_ready.
  - Output holds stable while vld && !ready.
- Fetch condition (READ only): free && entry_vld[rd_ptr] && (!entry_32_start[rd_ptr] || entry_vld[rd_ptr+1]).
  - rd_ptr+1 wraps modulo ENTRY_NUM.
- On fetch (1-cycle latency to output):
  - 32-bit: data={entry[rd_ptr+1],entry[rd_ptr]}, inst_32=1, advance 2.
  - 16-bit: data={16'b0,entry[rd_ptr]}, inst_32=0, advance 1.
  - lbuf_inst_back_br=entry_back_br[rd_ptr].
  - Next rd_ptr = back_br ? lbuf_loop_start_ptr : (rd_ptr+adv) mod ENTRY_NUM.
  - entry_fence[rd_ptr] → instruction still issued; state→EXIT; no further fetch.
  - Flags are always taken from the start halfword only.
- No fetch in READ with free=1 (underrun, including the upper half of a 32-bit inst not yet valid):
  - lbuf_inst_vld deasserts after any accept.
  - rd_ptr holds; state stays READ.
- No fetch while !free: output and rd_ptr hold.
- Throughput: 1 inst/cycle sustained with ready=1.

Optional Feature:
- Macro: LBUF_LOOP_CNT_EN.
- Defined:
  - lbuf_loop_cnt increments by 1 on every fetch with back_br=1, saturating at 255.
  - Cleared on active_start, flush or fill_state_enter.
- Undefined: counter register removed; lbuf_loop_cnt tied to 8'd0.

Test Plan:
- Reset → all outputs 0; state IDLE. Then active_start with start_ptr=3 → lbuf_rd_ptr=3 next cycle.
- Entries 3,4 valid, 32_start[3]=1, data 0x1234/0xABCD, ready=1 → next cycle vld=1, data=0xABCD1234, inst_32=1, rd_ptr=5.
- Loop body 3..6 all 16-bit, back_br[6]=1, ready=1:
  - Ptr sequence 3,4,5,6,3,4,…
  - back_br output high on the entry-6 instruction.
  - With LBUF_LOOP_CNT_EN, loop_cnt=2 after two passes.
- ENTRY_NUM=16, start_ptr=15, 32_start[15]=1: upper half taken from entry 0, rd_ptr wraps to 1. With entry_vld[0]=0: no output, rd_ptr holds 15.
- ready=0 for 3 cycles with vld=1 → data and rd_ptr stable. Fence at rd_ptr: inst issued → EXIT; rd_exit pulses 1 cycle after acceptance → IDLE.
- Flush asserted in the same cycle as an accept and a pending fetch → next cycle vld=0, rd_ptr=0, IDLE, no rd_exit.
